// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) with FWFT byte FIFO.
// Optional macro: UART_RX_PARITY_EN enables the even-parity bit.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rx_i,
  output logic [7:0]                   rdata_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic [$clog2(FIFO_DEPTH):0]  level_o,
  output logic                         frame_err_o,
  output logic                         overrun_o,
  output logic                         parity_err_o
);

  localparam int CPB   = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] HALF = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CPB - 1);
  localparam logic [AW:0]      LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  generate
    if (CPB < 4) begin : g_cpb_chk
      $error("uart_rx_fifo: CLK_FREQ/BAUD_RATE must be >= 4");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_rx_fifo: FIFO_DEPTH must be a power of two in 2..256");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             rx_q;
  logic             rx_s;

  logic             stop_hit;
  logic             par_bad;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_q <= rx_i;
      rx_s <= rx_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_bit <= 1'b0;
    end else if (state == PARITY && cnt == '0) begin
      par_bit <= rx_s;
    end
  end

  assign par_bad = ^{shreg, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= HALF;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            state <= DATA;
            cnt   <= FULL;
            idx   <= '0;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= FULL;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            cnt   <= FULL;
            state <= STOP;
          end
`else
          state <= IDLE;
`endif
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= rx_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stop_hit = (state == STOP) && (cnt == '0);
  assign push     = stop_hit && rx_s && !par_bad;
  assign pop      = rvalid_o && rready_i;
  assign full     = (count == LVL_FULL);
  // A full FIFO still accepts a byte when the head leaves in the same cycle
  assign wr_en    = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_hit && !rx_s;
      overrun_o   <= push && full && !pop;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_err_o <= 1'b0;
    end else begin
      parity_err_o <= stop_hit && rx_s && par_bad;
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif

  assign rvalid_o = (count != '0);
  assign rdata_o  = rvalid_o ? mem[rd_ptr] : 8'h00;
  assign level_o  = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo at 16 clocks per bit.
// Frames are modelled as byte queues; the monitor checks every pop.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // sync (2) + half bit + 8 data bits + parity + stop point, in clock edges
  localparam int PUSH_EDGE = 3 + CPB / 2 + CPB * (9 + PAR);

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic [3:0] level;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] mq[$];
  int n_ferr = 0, n_ovr = 0, n_perr = 0;
  int exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
  logic ferr_q = 0, ovr_q = 0, perr_q = 0;
  int last_pop = -1;
  bit done;

  uart_rx_fifo #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_i        (rx),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .level_o     (level),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .parity_err_o(parity_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h @%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid && rready) begin
        if (mq.size() == 0) begin
          chk("unexpected_pop", int'(rdata), -1);
        end else begin
          chk("pop_data", int'(rdata), int'(mq.pop_front()));
          last_pop = int'(rdata);
        end
      end
      if (frame_err) begin
        n_ferr++;
        chk("ferr_width", int'(ferr_q), 0);
      end
      if (overrun) begin
        n_ovr++;
        chk("ovr_width", int'(ovr_q), 0);
      end
      if (parity_err) begin
        n_perr++;
        chk("perr_width", int'(perr_q), 0);
      end
    end
    ferr_q = frame_err;
    ovr_q  = overrun;
    perr_q = parity_err;
  end

  // Called at posedge+1; holds rx for n bit periods.
  task automatic bit_out(input logic v, input int n);
    rx = v;
    repeat (n * CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low,
                            input bit bad_par);
    bit_out(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_out(b[i], 1);
`ifdef UART_RX_PARITY_EN
    bit_out((^b) ^ bad_par, 1);
`else
    if (bad_par) $display("note: parity request ignored in 8N1 build");
`endif
    if (stop_low > 0) bit_out(1'b0, stop_low);
    bit_out(1'b1, 1);
  endtask

  // Model: a byte arriving at a full FIFO with no pop is dropped.
  task automatic send_good(input logic [7:0] b);
    if (mq.size() >= DEPTH) exp_ovr++;
    else mq.push_back(b);
    send_frame(b, 0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rready = 1;
    while (mq.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    rready = 0;
    chk("drain_left", mq.size(), 0);
    @(negedge clk);
    chk("drain_level", int'(level), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    rst_n = 0;
    rx = 1;
    rready = 0;
    done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", int'(rdata), 0);
    chk("rst_rvalid", int'(rvalid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_perr", int'(parity_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;

    // single byte, exact push timing
    mq.push_back(8'hA5);
    fork
      send_frame(8'hA5, 0, 1'b0);
      begin
        repeat (PUSH_EDGE - 1) @(posedge clk);
        @(negedge clk);
        chk("pre_push_rvalid", int'(rvalid), 0);
        @(negedge clk);
        chk("push_rvalid", int'(rvalid), 1);
        chk("push_rdata", int'(rdata), 8'hA5);
        chk("push_level", int'(level), 1);
      end
    join
    rready = 1;
    @(posedge clk);
    #1;
    rready = 0;
    @(negedge clk);
    chk("pop_level", int'(level), 0);
    @(posedge clk);
    #1;

    // glitch shorter than half a bit
    rx = 0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    chk("glitch_rvalid", int'(rvalid), 0);
    chk("glitch_ferr", n_ferr, 0);
    @(posedge clk);
    #1;

    // framing error with long break, then a good byte
    send_frame(8'h3C, 3, 1'b0);
    exp_ferr++;
    bit_out(1'b1, 2);
    send_good(8'h11);
    bit_out(1'b1, 1);
    chk("ferr_count", n_ferr, exp_ferr);
    chk("ferr_level", int'(level), 1);
    drain();

    // random bytes with a random consumer
    done = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          b = 8'($urandom);
          send_good(b);
          bit_out(1'b1, $urandom_range(0, 2));
        end
        done = 1;
      end
      begin
        while (!done) begin
          rready = 1'($urandom);
          @(posedge clk);
          #1;
        end
        rready = 0;
      end
    join
    drain();

    // overrun: nine bytes into eight entries
    for (int i = 0; i < 9; i++) send_good(8'(i));
    @(negedge clk);
    chk("ovr_level", int'(level), DEPTH);
    chk("ovr_count", n_ovr, exp_ovr);
    @(posedge clk);
    #1;

    // push into a full FIFO while the head leaves in the same cycle
    mq.push_back(8'h5A);
    fork
      send_frame(8'h5A, 0, 1'b0);
      begin
        repeat (PUSH_EDGE - 1) @(posedge clk);
        #1;
        rready = 1;
        @(posedge clk);
        #1;
        rready = 0;
      end
    join
    @(negedge clk);
    chk("simul_level", int'(level), DEPTH);
    chk("simul_ovr", n_ovr, exp_ovr);
    @(posedge clk);
    #1;
    drain();
    chk("simul_last", last_pop, 8'h5A);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 0, 1'b1);
    exp_perr++;
    send_good(8'h07);
    bit_out(1'b1, 1);
    chk("perr_level", int'(level), 1);
    drain();
`endif
    chk("perr_count", n_perr, exp_perr);

    // reset mid-frame empties the FIFO and aborts the frame
    send_good(8'h99);
    fork
      send_frame(8'h42, 0, 1'b0);
      begin
        repeat (5 * CPB) @(posedge clk);
        #2;
        rst_n = 0;
      end
    join
    mq.delete();
    @(negedge clk);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_rvalid", int'(rvalid), 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    bit_out(1'b1, 2);
    chk("post_rst_level", int'(level), 0);
    send_good(8'hC3);
    bit_out(1'b1, 1);
    drain();

    chk("final_ferr", n_ferr, exp_ferr);
    chk("final_ovr", n_ovr, exp_ovr);
    chk("final_perr", n_perr, exp_perr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the subsystem `rx_i` pin. It is the receive counterpart of the existing `tx_o` serial path.
- Deserialises 8N1 frames (optionally 8E1) from the host into bytes.
- Buffers received bytes in a small first-word-fall-through FIFO.
- Presents bytes to the memory-mapped peripheral logic through a valid/ready port.
- Sits beside the RAM/peripheral responder on the divided core clock.

Parameters:
- CLK_FREQ, 25_000_000: input clock frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate.
- FIFO_DEPTH, 8: receive buffer entries. Must be a power of two, 2..256.

Ports:
- clk_i  input  1  core clock (divided clock)
- rst_ni  input  1  asynchronous active-low reset
- rx_i  input  1  serial input, asynchronous to clk_i, idle high
- rdata_o  output  8  FIFO head byte
- rvalid_o  output  1  FIFO non-empty
- rready_i  input  1  consumer accepts head byte
- level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- overrun_o  output  1  one-cycle pulse: byte dropped because FIFO was full
- parity_err_o  output  1  one-cycle pulse: parity mismatch (tied 0 without the macro)

Behaviour:
- Clocking and reset:
  - One clock, clk_i. Reset rst_ni is asynchronous and active-low.
  - Reset values: rdata_o=0, rvalid_o=0, level_o=0, all error pulses 0, FSM=IDLE, FIFO pointers 0, synchroniser flops 1.
  - Reset asserted mid-frame aborts the frame and empties the FIFO.
  - After reset release, reception restarts only on the next falling edge.
- Bit timing:
  - CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer floor.
  - Elaboration fails ($error) if CLKS_PER_BIT < 4.
  - Bit counter width is $clog2(CLKS_PER_BIT).
- Input synchronisation: rx_i passes through a 2-flop synchroniser. All decisions use the synchronised value rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 → START, with the counter loaded for a half-bit wait (CLKS_PER_BIT/2 - 1).
  - START: at half-bit expiry, rx_s==1 → IDLE (glitch, no pulse, nothing stored). rx_s==0 → DATA, with a full-bit wait and bit index 0.
  - DATA: at each full-bit expiry, sample rx_s into the shift register, LSB first. After bit 7 → PARITY if the macro is defined, else → STOP.
  - PARITY: sample at the full-bit point, then → STOP.
  - STOP: at the full-bit point, rx_s==1 → push the byte and go to IDLE. rx_s==0 → frame_err_o pulse, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s==1, then → IDLE. This prevents a break condition from generating repeated frames.
- FIFO:
  - Push occurs in the stop-sample cycle. rvalid_o and level_o reflect the new byte on the next cycle.
  - Pop occurs on rvalid_o && rready_i. rdata_o is the head entry; it changes on the cycle after a pop.
  - Push while full with no pop: byte dropped, overrun_o pulses, contents unchanged.
  - Push and pop in the same cycle when full: both are performed, no overrun, level unchanged.
  - Push and pop in the same cycle when empty: not possible, because rvalid_o=0.
  - Pointers wrap modulo FIFO_DEPTH. level_o ranges 0..FIFO_DEPTH.
- Error pulse reporting: frame_err_o, parity_err_o and overrun_o each last exactly one cycle. Error pulses are independent of the consumer handshake.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; the PARITY state is entered.
  - If the XOR of the 8 data bits and the parity bit is 1, parity_err_o pulses in the stop-sample cycle and the byte is discarded.
  - A frame with both a parity error and a stop-bit error reports only frame_err_o.
- Undefined:
  - Frame is 8N1 and the PARITY state is unreachable.
  - parity_err_o is tied to 0.

Test Plan:
- Single byte: CLK_FREQ=1_600_000, BAUD_RATE=100_000 (16 clk/bit); send 0xA5, rready_i=0. Expect rvalid_o=1 with rdata_o=0xA5 and level_o=1 one cycle after the stop sample. A pop returns level_o to 0.
- Glitch rejection: drive rx_i low for 4 clocks, then high. Expect FSM back in IDLE, rvalid_o=0, no error pulses.
- Framing error: send 0x3C with the stop bit held low for 3 bit times, then high, then a valid 0x11. Expect one frame_err_o pulse; only 0x11 enters the FIFO.
- Overrun: FIFO_DEPTH=8, rready_i=0; send 0x00..0x08. Expect level_o=8, one overrun_o pulse on the 9th byte, and pops return 0x00..0x07 in order.
- Full with simultaneous pop: with level_o=8, assert rready_i in exactly the push cycle of a 10th byte 0x5A. Expect no overrun, level_o stays 8, and 0x5A is the last byte popped.
- Parity (macro defined): send 0x07 with parity bit 0 (wrong). Expect a parity_err_o pulse and no push. Send 0x07 with parity bit 1. Expect a push of 0x07.
